// File: rtl/dav_pkg.sv
// Shared types and constants for the display/audio path: scheduler states,
// default bank geometry and RGB332 colours used by the colour determiner.
package dav_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } sched_state_t;

  localparam int DEF_SAMPLES  = 32;
  localparam int DEF_SAMPLE_W = 8;

  // RGB332 palette: rrr_ggg_bb
  localparam logic [7:0] RGB_BLACK  = 8'h00;
  localparam logic [7:0] RGB_RED    = 8'hE0;
  localparam logic [7:0] RGB_GREEN  = 8'h1C;
  localparam logic [7:0] RGB_BLUE   = 8'h03;
  localparam logic [7:0] RGB_YELLOW = 8'hFC;
  localparam logic [7:0] RGB_WHITE  = 8'hFF;

endpackage

// File: rtl/bank_fill_counter.sv
// Fill side of the ping-pong scheduler: write strobe/address/data, fill count,
// bank_full flag and the bank select. Optional drop counter under DROP_CNT_EN.
module bank_fill_counter
  import dav_pkg::*;
#(
  parameter int SAMPLES  = DEF_SAMPLES,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int IDX_W    = $clog2(SAMPLES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                swap,
  output logic                wr_en,
  output logic                wr_bank,
  output logic [IDX_W-1:0]    wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                bank_full
`ifdef DROP_CNT_EN
  ,
  output logic [7:0]          drop_cnt
`endif
);

  // One extra bit so a count of SAMPLES is representable.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLES);

  logic                wr_en_q, wr_en_d;
  logic                wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]    wr_addr_q, wr_addr_d;
  logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                bank_full_q, bank_full_d;
  logic [CNT_W-1:0]    base_count_s;
  logic                accept_s;

  // A swap rebases the fill onto the other bank before the same-cycle sample lands.
  always_comb begin
    wr_bank_d    = swap ? ~wr_bank_q : wr_bank_q;
    base_count_s = swap ? {CNT_W{1'b0}} : count_q;
    accept_s     = sample_valid && (swap || !bank_full_q);
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    count_d      = base_count_s;
    if (accept_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = base_count_s[IDX_W-1:0];
      wr_data_d = sample_data;
      count_d   = base_count_s + CNT_W'(1);
    end else begin
      wr_en_d   = 1'b0;
    end
    bank_full_d = (count_d == CNT_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q     <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= {IDX_W{1'b0}};
      wr_data_q   <= {SAMPLE_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      bank_full_q <= 1'b0;
    end else begin
      wr_en_q     <= wr_en_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      count_q     <= count_d;
      bank_full_q <= bank_full_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_bank   = wr_bank_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign bank_full = bank_full_q;

`ifdef DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of samples refused while the fill bank waits for a swap.
  always_comb begin
    if (sample_valid && !accept_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: rtl/sample_bank_scheduler.sv
// Ping-pong scheduler between two sample RAMs: swap decision and display reader FSM.
// Define DROP_CNT_EN to add the saturating drop_cnt output.
module sample_bank_scheduler
  import dav_pkg::*;
#(
  parameter int SAMPLES  = DEF_SAMPLES,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int IDX_W    = $clog2(SAMPLES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                frame_start,
  input  logic                scan_ready,
  output logic                wr_en,
  output logic                wr_bank,
  output logic [IDX_W-1:0]    wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                whichRAM,
  output logic [IDX_W-1:0]    index_holder,
  output logic                done,
  output logic                bank_full
`ifdef DROP_CNT_EN
  ,
  output logic [7:0]          drop_cnt
`endif
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES - 1);

  logic             swap_s;
  logic             wr_bank_s;
  logic             bank_full_s;
  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             which_q, which_d;
  logic             done_q, done_d;

  bank_fill_counter #(
    .SAMPLES  (SAMPLES),
    .SAMPLE_W (SAMPLE_W),
    .IDX_W    (IDX_W)
  ) u_fill (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .swap         (swap_s),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank_s),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .bank_full    (bank_full_s)
`ifdef DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  assign swap_s = frame_start && bank_full_s;

  // Reader next state; a swap publishes the bank that was just filled.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    which_d = which_q;
    if (swap_s) begin
      state_d = S_SCAN;
      index_d = {IDX_W{1'b0}};
      which_d = wr_bank_s;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
          index_d = {IDX_W{1'b0}};
        end
        S_SCAN: begin
          if (frame_start) begin
            index_d = {IDX_W{1'b0}};
          end else if (scan_ready) begin
            if (index_q == IDX_LAST) begin
              state_d = S_HOLD;
            end else begin
              index_d = index_q + IDX_W'(1);
            end
          end else begin
            index_d = index_q;
          end
        end
        S_HOLD: begin
          if (frame_start) begin
            state_d = S_SCAN;
            index_d = {IDX_W{1'b0}};
          end else begin
            index_d = IDX_LAST;
          end
        end
        default: begin
          state_d = S_IDLE;
          index_d = {IDX_W{1'b0}};
        end
      endcase
    end
    done_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= {IDX_W{1'b0}};
      which_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      which_q <= which_d;
      done_q  <= done_d;
    end
  end

  assign wr_bank      = wr_bank_s;
  assign bank_full    = bank_full_s;
  assign whichRAM     = which_q;
  assign index_holder = index_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sample_bank_scheduler.sv
// Self-checking bench for sample_bank_scheduler: directed vector table, async
// reset check, then randomized traffic against a behavioural model.
module tb_sample_bank_scheduler;

  localparam int S = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_data = 8'd0;
  logic       frame_start = 1'b0;
  logic       scan_ready = 1'b0;
  logic       wr_en, wr_bank, whichRAM, done, bank_full;
  logic [4:0] wr_addr, index_holder;
  logic [7:0] wr_data;
`ifdef DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sample_bank_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .frame_start  (frame_start),
    .scan_ready   (scan_ready),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .whichRAM     (whichRAM),
    .index_holder (index_holder),
    .done         (done),
    .bank_full    (bank_full)
`ifdef DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  typedef struct {
    logic sv; logic [7:0] sd; logic fs; logic sr;
    logic en; logic bank; logic [4:0] addr; logic [7:0] data;
    logic which; logic [4:0] idx; logic dn; logic full;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic sv, input logic [7:0] sd, input logic fs, input logic sr,
                              input logic en, input logic bank, input logic [4:0] addr,
                              input logic [7:0] data, input logic which, input logic [4:0] idx,
                              input logic dn, input logic full);
    vec_t v;
    v.sv = sv; v.sd = sd; v.fs = fs; v.sr = sr;
    v.en = en; v.bank = bank; v.addr = addr; v.data = data;
    v.which = which; v.idx = idx; v.dn = dn; v.full = full;
    vecs.push_back(v);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, ".wr_en"}, 32'(wr_en), 32'd0);
    cmp({tag, ".wr_bank"}, 32'(wr_bank), 32'd0);
    cmp({tag, ".wr_addr"}, 32'(wr_addr), 32'd0);
    cmp({tag, ".wr_data"}, 32'(wr_data), 32'd0);
    cmp({tag, ".whichRAM"}, 32'(whichRAM), 32'd1);
    cmp({tag, ".index"}, 32'(index_holder), 32'd0);
    cmp({tag, ".done"}, 32'(done), 32'd0);
    cmp({tag, ".bank_full"}, 32'(bank_full), 32'd0);
  endtask

  task automatic drive(input logic sv, input logic [7:0] sd, input logic fs, input logic sr);
    sample_valid = sv; sample_data = sd; frame_start = fs; scan_ready = sr;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
  endtask

  // Behavioural reference: bank/fill bookkeeping and publish/scan rules.
  logic m_en, m_bank, m_which, m_done, m_full, m_scanning;
  logic [7:0] m_data;
  int m_addr, m_idx, m_count, m_drop;

  task automatic model_reset();
    m_en = 0; m_bank = 0; m_which = 1; m_done = 0; m_full = 0; m_scanning = 0;
    m_data = 0; m_addr = 0; m_idx = 0; m_count = 0; m_drop = 0;
  endtask

  task automatic model_step(input logic sv, input logic [7:0] sd, input logic fs, input logic sr);
    if (fs && m_full) begin
      m_which = m_bank; m_bank = ~m_bank; m_count = 0; m_full = 0;
      m_idx = 0; m_done = 1; m_scanning = 1;
    end else if (fs && m_done) begin
      m_idx = 0; m_scanning = 1;
    end else if (m_done && sr && m_scanning) begin
      if (m_idx == S - 1) m_scanning = 0;
      else m_idx = m_idx + 1;
    end
    if (sv && !m_full) begin
      m_en = 1; m_addr = m_count; m_data = sd; m_count = m_count + 1;
      m_full = (m_count == S);
    end else begin
      m_en = 0;
      if (sv && m_drop < 255) m_drop = m_drop + 1;
    end
  endtask

  initial begin
    // Directed scenario table.
    for (int i = 0; i < S; i++)
      add(1, 8'(i), 0, 0, 1, 0, 5'(i), 8'(i), 1, 0, 0, (i == S - 1));
    for (int k = 0; k < 5; k++)
      add(1, 8'(8'hA0 + k), 0, 0, 0, 0, 5'd31, 8'd31, 1, 0, 0, 1);
    add(1, 8'h55, 1, 0, 1, 1, 5'd0, 8'h55, 0, 0, 1, 0);
    add(1, 8'h77, 0, 0, 1, 1, 5'd1, 8'h77, 0, 0, 1, 0);
    for (int k = 1; k <= 33; k++)
      add(0, 8'd0, 0, 1, 0, 1, 5'd1, 8'h77, 0, 5'((k > 31) ? 31 : k), 1, 0);
    add(0, 8'd0, 1, 0, 0, 1, 5'd1, 8'h77, 0, 5'd0, 1, 0);
    for (int k = 1; k <= 12; k++)
      add(0, 8'd0, 0, 1, 0, 1, 5'd1, 8'h77, 0, 5'(k), 1, 0);
    add(0, 8'd0, 1, 1, 0, 1, 5'd1, 8'h77, 0, 5'd0, 1, 0);
    add(0, 8'd0, 0, 1, 0, 1, 5'd1, 8'h77, 0, 5'd1, 1, 0);

    reset = 1'b1;
    #12;
    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].sv, vecs[i].sd, vecs[i].fs, vecs[i].sr);
      @(posedge clk);
      #1;
      cmp($sformatf("v%0d.wr_en", i), 32'(wr_en), 32'(vecs[i].en));
      cmp($sformatf("v%0d.wr_bank", i), 32'(wr_bank), 32'(vecs[i].bank));
      cmp($sformatf("v%0d.wr_addr", i), 32'(wr_addr), 32'(vecs[i].addr));
      cmp($sformatf("v%0d.wr_data", i), 32'(wr_data), 32'(vecs[i].data));
      cmp($sformatf("v%0d.whichRAM", i), 32'(whichRAM), 32'(vecs[i].which));
      cmp($sformatf("v%0d.index", i), 32'(index_holder), 32'(vecs[i].idx));
      cmp($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].dn));
      cmp($sformatf("v%0d.bank_full", i), 32'(bank_full), 32'(vecs[i].full));
    end
`ifdef DROP_CNT_EN
    cmp("drop_cnt_after_5", 32'(drop_cnt), 32'd5);
`endif

    // Asynchronous reset mid-scan, sampled between clock edges.
    drive(0, 8'd0, 0, 1);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
`ifdef DROP_CNT_EN
    cmp("async_reset.drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      logic sv, fs, sr;
      logic [7:0] sd;
      sv = ($urandom_range(0, 9) < 7);
      sd = 8'($urandom);
      fs = ($urandom_range(0, 24) == 0);
      sr = $urandom_range(0, 1) != 0;
      drive(sv, sd, fs, sr);
      @(posedge clk);
      model_step(sv, sd, fs, sr);
      #1;
      cmp($sformatf("r%0d.wr_en", c), 32'(wr_en), 32'(m_en));
      cmp($sformatf("r%0d.wr_bank", c), 32'(wr_bank), 32'(m_bank));
      cmp($sformatf("r%0d.wr_addr", c), 32'(wr_addr), 32'(m_addr));
      cmp($sformatf("r%0d.wr_data", c), 32'(wr_data), 32'(m_data));
      cmp($sformatf("r%0d.whichRAM", c), 32'(whichRAM), 32'(m_which));
      cmp($sformatf("r%0d.index", c), 32'(index_holder), 32'(m_idx));
      cmp($sformatf("r%0d.done", c), 32'(done), 32'(m_done));
      cmp($sformatf("r%0d.bank_full", c), 32'(bank_full), 32'(m_full));
`ifdef DROP_CNT_EN
      cmp($sformatf("r%0d.drop_cnt", c), 32'(drop_cnt), 32'(m_drop));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
